// File: rtl/shared_pow2_divider_arbiter.sv
// shared_pow2_divider_arbiter: round-robin scheduler sharing one signed power-of-two divider
`timescale 1ns/1ps
module shared_pow2_divider_arbiter #(
    parameter int N  = 8,
    parameter int R  = 4,
    parameter int SW = $clog2(N),
    parameter int IW = $clog2(R)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [R-1:0]    i_req_valid,
    output logic [R-1:0]    o_req_ready,
    input  logic [R*N-1:0]  i_req_data,
    input  logic [R*SW-1:0] i_req_shift,
    input  logic [R-1:0]    i_req_trunc,
    output logic            o_res_valid,
    input  logic            i_res_ready,
    output logic [N-1:0]    o_res_data,
    output logic [IW-1:0]   o_res_id
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t r_state, w_next;
    logic [IW-1:0] r_ptr, r_id, w_gnt, w_idx;
    logic [N-1:0] r_data;
    logic w_any, w_can, w_xfer, w_t;
    logic signed [N-1:0] w_a, w_bias, w_sum, w_q;
    logic [SW-1:0] w_s, w_sc;

    // first valid requester at or after the round-robin pointer; scanning
    // backwards lets the nearest one overwrite farther candidates
    always_comb begin
        w_gnt = '0;
        w_any = 1'b0;
        w_idx = '0;
        for (int k = R - 1; k >= 0; k--) begin
            w_idx = IW'((int'(r_ptr) + k) % R);
            if (i_req_valid[w_idx]) begin
                w_gnt = w_idx;
                w_any = 1'b1;
            end
        end
    end

    // gate with rst_n so no handshake can complete while reset is held
    assign w_can       = !o_res_valid || i_res_ready;
    assign w_xfer      = rst_n && w_any && w_can;
    assign o_req_ready = w_xfer ? (R'(1) << w_gnt) : '0;

    // operand mux for the granted requester
    always_comb begin
        w_a = '0;
        w_s = '0;
        w_t = 1'b0;
        for (int i = 0; i < R; i++) begin
            if (w_gnt == IW'(i)) begin
                w_a = i_req_data[i*N +: N];
                w_s = i_req_shift[i*SW +: SW];
                w_t = i_req_trunc[i];
            end
        end
    end

    // shifts beyond N-1 are only encodable when N is not a power of two
    if ((1 << SW) == N) begin : g_noclamp
        assign w_sc = w_s;
    end else begin : g_clamp
        assign w_sc = (w_s > SW'(N - 1)) ? SW'(N - 1) : w_s;
    end

    // truncation biases negative operands by 2**s-1 before the floor shift
    assign w_bias = (N'(1) << w_sc) - N'(1);
    assign w_sum  = (w_t && w_a[N-1]) ? w_a + w_bias : w_a;
    assign w_q    = w_sum >>> w_sc;

    // result register occupancy: accept fills, consume without accept empties
    always_comb begin
        w_next = r_state;
        if (w_xfer)
            w_next = FULL;
        else if (i_res_ready)
            w_next = EMPTY;
    end

    // state, result and pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
            r_data  <= '0;
            r_id    <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_next;
            if (w_xfer) begin
                r_data <= w_q;
                r_id   <= w_gnt;
                r_ptr  <= (w_gnt == IW'(R - 1)) ? '0 : w_gnt + 1'b1;
            end
        end
    end

    assign o_res_valid = (r_state == FULL);
    assign o_res_data  = r_data;
    assign o_res_id    = r_id;
endmodule

// File: doc/shared_pow2_divider_arbiter.md
# shared_pow2_divider_arbiter

Round-robin scheduler that shares one signed power-of-two divide unit among R requesters. Each request carries a signed N-bit operand, a shift amount and a rounding mode: floor (arithmetic right shift) or truncation toward zero (true signed `a / 2**s`). The block arbitrates valid/ready request channels, computes in a single registered stage, and returns tagged results on one valid/ready output channel with backpressure.

## Interface
- `N`, 8, operand/result width in bits (N >= 2)
- `R`, 4, number of requesters (R >= 2)
- `SW`, `$clog2(N)`, shift-amount width; legal shift 0..N-1
- `IW`, `$clog2(R)`, requester-ID width
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  R  request valid, bit i = requester i
- `req_ready`  out  R  request accepted this cycle when valid & ready
- `req_data`  in  R*N  signed operand, requester i at [i*N +: N]
- `req_shift`  in  R*SW  shift amount s, requester i at [i*SW +: SW]
- `req_trunc`  in  R  1 = round toward zero, 0 = floor
- `res_valid`  out  1  result register holds a result
- `res_ready`  in  1  consumer accepts result
- `res_data`  out  N  signed quotient
- `res_id`  out  IW  index of the requester that produced `res_data`

## Operation
- **Arithmetic, per accepted request (a, s, t):**
  - floor: `a >>> s`.
  - trunc with `a < 0`: `(a + (2**s - 1)) >>> s`.
  - trunc with `a >= 0`: `a >>> s`.
  - The bias addition cannot overflow for `s <= N-1`.
- **Illegal shift:** `s >= N` (possible only when N is not a power of two) is clamped to N-1.
- **Can-accept:** `can_accept = !res_valid || res_ready`.
- **Arbitration:**
  - Round-robin pointer `ptr` (IW bits).
  - Grant goes to the first i with `req_valid[i]`, scanning `ptr, ptr+1, …` modulo R.
  - `req_ready` is one-hot on the granted index and is asserted only when `can_accept`. All other `req_ready` bits are 0.
  - `req_ready` depends combinationally on `req_valid`, `res_valid`, `res_ready` and `ptr`; there is no combinational path from `req_data`.
- **On a transfer from requester g:**
  - The result register loads `{quotient, g}`.
  - `res_valid` is set to 1.
  - `ptr` becomes `(g+1) mod R` (wraps from R-1 to 0).
- **No transfer, result consumed:** when `res_valid && res_ready`, `res_valid` is cleared to 0.
- **No transfer, result not consumed:** when `res_valid && !res_ready`, `res_data` and `res_id` hold stable.
- **Idle:** with no requests valid, `ptr` is unchanged.
- **Single state bit:** `res_valid` (EMPTY/FULL). Transitions:
  - EMPTY→FULL on accept.
  - FULL→FULL on accept with `res_ready` (replace), or on `!res_ready` (hold).
  - FULL→EMPTY on `res_ready` with no accept.

## Timing
- **Reset values (asynchronous, at `rst_n` = 0):** `res_valid`=0, `res_data`=0, `res_id`=0, `ptr`=0. `req_ready` reads 0 while `rst_n` is low.
- **Reset mid-operation:** a pending result is discarded. The first grant after reset starts from requester 0.
- **Latency:** a request accepted at edge k produces `res_valid`=1 with its result after edge k, i.e. one cycle.
- **Throughput:** one result per cycle when `res_ready` is held at 1.
- **Backpressure:** `res_ready`=0 while `res_valid`=1 forces every `req_ready` bit to 0. No request is lost or duplicated.
- **Simultaneous events:** consume and accept in the same cycle is legal. The register is replaced and `res_valid` stays 1.
- **Fairness:** with all R requesters continuously valid and `res_ready`=1, grants cycle 0,1,…,R-1,0. No requester waits more than R-1 transfers.

## Test plan
- **Floor vs. trunc, single requester 0:**
  - a=-7, s=1, t=0 → res_data=-4, res_id=0, one cycle after accept.
  - a=-7, s=1, t=1 → -3.
  - a=100, s=2 → 25 in both modes.
- **Edge operands:**
  - a=-128, s=7: floor -1, trunc -1.
  - a=-1, s=3: floor -1, trunc 0.
  - a=127, s=0 → 127.
  - a=-128, s=0 → -128.
  - Random a/s sweep checked against `$floor`/`/` reference math.
- **Round-robin, all four requesters valid, `res_ready`=1:** res_id sequence 0,1,2,3,0,1. After reset with only req 2 and req 0 valid: 0, 2, 0, 2.
- **Backpressure:**
  - Hold `res_ready`=0 for 5 cycles with requests pending. Check `req_ready`=0 and that res_data/res_id stay stable.
  - Release `res_ready`: the next grant occurs in the same cycle as the consume; no result is dropped.
- **Reset mid-stream:** assert `rst_n`=0 asynchronously while `res_valid`=1 and `ptr`=3. Check immediately: res_valid=0, res_data=0, res_id=0. The first grant after release goes to the lowest-indexed valid requester.
